adder_scan_display: RTL and testbench

//  Parametrised button adder/subtractor driving the 4-digit multiplexed 7-seg display.

---
 rtl/adder_scan_pkg.sv | 46 ++++
 rtl/adder_scan_display_btn_debounce.sv | 59 +++++
 rtl/adder_scan_display.sv | 150 +++++++++++++++
 tb/tb_adder_scan_display.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_scan_pkg.sv
// ============================================================================
//  Module   : adder_scan_pkg
//  Purpose  : Shared types, constants and 7-segment decode for adder_scan_display.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_scan_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_CLR
    } op_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         NUM_DIGITS = 4;

    // Segment order {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h01;
            4'h1:    s = 7'h4F;
            4'h2:    s = 7'h12;
            4'h3:    s = 7'h06;
            4'h4:    s = 7'h4C;
            4'h5:    s = 7'h24;
            4'h6:    s = 7'h20;
            4'h7:    s = 7'h0F;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h04;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h60;
            4'hC:    s = 7'h31;
            4'hD:    s = 7'h42;
            4'hE:    s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_scan_display_btn_debounce.sv
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser plus stable-interval debouncer; emits a
//             one-cycle pulse on each debounced press.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int                c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_state;
    logic               r_state_d;
    logic               r_pulse;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_state_d <= r_state;
            r_pulse   <= r_state & ~r_state_d;
            // Any return to agreement restarts the stability interval.
            if (r_sync2 != r_state) begin
                if (r_cnt == c_cnt_last) begin
                    r_state <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/adder_scan_display.sv
// ============================================================================
//  Module   : adder_scan_display
//  Purpose  : Button-driven adder/subtractor shown in hex on a 4-digit
//             multiplexed 7-segment display. Macro ADDER_SCAN_BLANK_EN enables
//             leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_scan_display
    import adder_scan_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             btn_add,
    input  logic             btn_sub,
    input  logic             btn_clr,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [3:0]       an
);

    localparam int                c_div_w    = $clog2(SCAN_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);

    logic w_add_p;
    logic w_sub_p;
    logic w_clr_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_add (
        .clk(clk), .reset(reset), .raw(btn_add), .pulse(w_add_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sub (
        .clk(clk), .reset(reset), .raw(btn_sub), .pulse(w_sub_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk(clk), .reset(reset), .raw(btn_clr), .pulse(w_clr_p)
    );

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    op_e            w_op;

    assign w_sum  = {1'b0, a_in} + {1'b0, b_in};
    assign w_diff = {1'b0, a_in} - {1'b0, b_in};

    always_comb begin
        w_op = OP_NONE;
        if (w_clr_p)      w_op = OP_CLR;
        else if (w_sub_p) w_op = OP_SUB;
        else if (w_add_p) w_op = OP_ADD;
    end

    logic [WIDTH:0] r_result;
    logic           r_flag;

    // The top bit of the extended difference is the borrow (a_in < b_in).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flag   <= 1'b0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_result <= '0;
                    r_flag   <= 1'b0;
                end
                OP_SUB: begin
                    r_result <= w_diff;
                    r_flag   <= w_diff[WIDTH];
                end
                OP_ADD: begin
                    r_result <= w_sum;
                    r_flag   <= w_sum[WIDTH];
                end
                default: ;
            endcase
        end
    end

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    logic [15:0] w_disp;
    logic [3:0]  w_nib;
    logic        w_blank;

    assign w_disp = 16'(r_result);

    always_comb begin
        w_nib   = w_disp[3:0];
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_nib = w_disp[7:4];
            2'd2:    w_nib = w_disp[11:8];
            2'd3:    w_nib = w_disp[15:12];
            default: w_nib = w_disp[3:0];
        endcase
`ifdef ADDER_SCAN_BLANK_EN
        case (r_idx)
            2'd1:    w_blank = (w_disp[15:4] == 12'd0);
            2'd2:    w_blank = (w_disp[15:8] == 8'd0);
            2'd3:    w_blank = (w_disp[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
`endif
    end

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    // All three outputs register together from the same index so digits never ghost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? SEG_BLANK : hex_to_seg(w_nib);
            r_dp  <= ~(r_flag && (r_idx == 2'd0));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_adder_scan_display.sv
// ============================================================================
//  Module   : tb_adder_scan_display
//  Purpose  : Self-checking bench for adder_scan_display against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_scan_display;

    localparam int WIDTH    = 8;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] a_in    = 8'h00;
    logic [7:0] b_in    = 8'h00;
    logic       btn_add = 1'b0;
    logic       btn_sub = 1'b0;
    logic       btn_clr = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    adder_scan_display #(
        .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .btn_add(btn_add), .btn_sub(btn_sub), .btn_clr(btn_clr),
        .seg(seg), .dp(dp), .an(an)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Behavioural model: raw samples per edge, debounced level, press pipeline.
    int         m_res   = 0;
    bit         m_flag  = 0;
    int         m_cyc   = 0;
    int         m_caps  = 0;
    bit         m_valid = 0;
    bit         hist  [3][8];
    bit         st    [3];
    bit         pipe0 [3];
    bit         pipe1 [3];
    logic [3:0] e_an  = 4'hF;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp  = 1'b1;

    always @(posedge clk) begin : model
        bit  raw [3];
        bit  cap [3];
        bit  all_diff;
        bit  rose;
        int  idx;
        int  av;
        int  bv;
        raw[0] = btn_add;
        raw[1] = btn_sub;
        raw[2] = btn_clr;
        m_valid = 1;
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                for (int j = 0; j < 8; j++) hist[b][j] = 0;
                st[b] = 0; pipe0[b] = 0; pipe1[b] = 0;
            end
            m_res = 0; m_flag = 0; m_cyc = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            idx   = (m_cyc / SCAN_DIV) % 4;
            e_an  = 4'hF;
            e_an[2'(idx)] = 1'b0;
            e_seg = seg_tab[4'((m_res >> (4 * idx)) & 15)];
`ifdef ADDER_SCAN_BLANK_EN
            if (idx > 0 && (m_res >> (4 * idx)) == 0) e_seg = 7'h7F;
`endif
            e_dp  = !(m_flag && idx == 0);
            for (int b = 0; b < 3; b++) begin
                // Level flips once the last DEB synchronised samples all disagree with it.
                all_diff = 1;
                for (int j = 1; j <= DEB; j++) if (hist[b][j] == st[b]) all_diff = 0;
                rose = 0;
                if (all_diff) begin
                    st[b] = !st[b];
                    rose  = st[b];
                end
                cap[b]   = pipe1[b];
                pipe1[b] = pipe0[b];
                pipe0[b] = rose;
                for (int j = 7; j > 0; j--) hist[b][j] = hist[b][j-1];
                hist[b][0] = raw[b];
            end
            av = a_in;
            bv = b_in;
            if (cap[2]) begin
                m_res = 0; m_flag = 0; m_caps++;
            end else if (cap[1]) begin
                m_res = (av - bv) & 511; m_flag = (av < bv); m_caps++;
            end else if (cap[0]) begin
                m_res = av + bv; m_flag = (m_res > 255); m_caps++;
            end
            m_cyc++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            chk("an",  32'(an),  32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp",  32'(dp),  32'(e_dp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic set_btns(input int mask);
        btn_add = mask[0];
        btn_sub = mask[1];
        btn_clr = mask[2];
    endtask

    task automatic press(input int mask, input int hold, input int rel);
        set_btns(mask);
        cycles(hold);
        set_btns(0);
        cycles(rel);
    endtask

    task automatic get_digit(input int k, output logic [6:0] s, output logic d);
        logic [3:0] pat;
        bit         found;
        pat = 4'hF;
        pat[2'(k)] = 1'b0;
        found = 0;
        s = 7'h7F;
        d = 1'b1;
        for (int i = 0; i < 32 && !found; i++) begin
            tick();
            if (an == pat) begin
                found = 1;
                s = seg;
                d = dp;
            end
        end
        chk("scan_found", 32'(found), 1);
    endtask

    initial begin : stim
        logic [6:0] s;
        logic       d;
        int         caps0;
        logic [6:0] exp_hi;

        // Reset held, then first scanned digit after release.
        cycles(5);
        chk("rst_an", 32'(an), 4'hF);
        chk("rst_seg", 32'(seg), 7'h7F);
        chk("rst_dp", 32'(dp), 1);
        reset = 1'b0;
        tick();
        chk("rel_an", 32'(an), 4'b1110);
        chk("rel_seg", 32'(seg), 7'h01);
        chk("rel_dp", 32'(dp), 1);
        chk("rel_res", m_res, 0);

        // FF + FF with latency pinned at t+DEB+3.
        a_in = 8'hFF; b_in = 8'hFF;
        set_btns(1);
        cycles(DEB + 3);
        chk("lat_before", m_res, 0);
        tick();
        chk("lat_at", m_res, 9'h1FE);
        cycles(8 - (DEB + 4));
        set_btns(0);
        cycles(6);
        chk("add_flag", 32'(m_flag), 1);
        get_digit(0, s, d); chk("d0_seg", 32'(s), 7'h30); chk("d0_dp", 32'(d), 0);
        get_digit(1, s, d); chk("d1_seg", 32'(s), 7'h38); chk("d1_dp", 32'(d), 1);
        get_digit(2, s, d); chk("d2_seg", 32'(s), 7'h4F); chk("d2_dp", 32'(d), 1);
        get_digit(3, s, d); chk("d3_seg", 32'(s), 7'h01); chk("d3_dp", 32'(d), 1);

        // Subtraction with and without borrow.
        a_in = 8'h05; b_in = 8'h07;
        press(2, 8, 6);
        chk("sub_borrow_res", m_res, 9'h1FE);
        chk("sub_borrow_flag", 32'(m_flag), 1);
        a_in = 8'h07; b_in = 8'h05;
        press(2, 8, 6);
        chk("sub_res", m_res, 9'h002);
        chk("sub_flag", 32'(m_flag), 0);
        get_digit(0, s, d); chk("sub_d0_seg", 32'(s), 7'h12); chk("sub_d0_dp", 32'(d), 1);

        // Bouncing button followed by a steady hold: one capture only.
        a_in = 8'h03; b_in = 8'h04;
        caps0 = m_caps;
        for (int i = 0; i < 3; i++) begin
            set_btns(1); cycles(2);
            set_btns(0); cycles(2);
        end
        press(1, 10, 8);
        chk("bounce_caps", m_caps - caps0, 1);
        chk("bounce_res", m_res, 7);

        // Clear wins over a simultaneous add.
        a_in = 8'hFF; b_in = 8'hFF;
        press(1, 8, 6);
        chk("pre_clr_res", m_res, 9'h1FE);
        caps0 = m_caps;
        press(5, 8, 6);
        chk("clr_res", m_res, 0);
        chk("clr_flag", 32'(m_flag), 0);
        chk("clr_caps", m_caps - caps0, 1);

        // Reset mid-debounce suppresses the press.
        caps0 = m_caps;
        set_btns(1);
        cycles(3);
        reset = 1'b1;
        set_btns(0);
        cycles(2);
        reset = 1'b0;
        cycles(10);
        chk("rst_mid_caps", m_caps - caps0, 0);

        // Leading-zero display of 005.
        a_in = 8'h02; b_in = 8'h03;
        press(1, 8, 6);
        chk("five_res", m_res, 5);
`ifdef ADDER_SCAN_BLANK_EN
        exp_hi = 7'h7F;
`else
        exp_hi = 7'h01;
`endif
        get_digit(0, s, d); chk("five_d0", 32'(s), 7'h24);
        get_digit(1, s, d); chk("five_d1", 32'(s), 32'(exp_hi));
        get_digit(2, s, d); chk("five_d2", 32'(s), 32'(exp_hi));
        get_digit(3, s, d); chk("five_d3", 32'(s), 32'(exp_hi));

        // Randomised operands, button combinations, hold lengths and resets.
        for (int i = 0; i < 60; i++) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            press($urandom_range(1, 7), $urandom_range(1, 9), $urandom_range(3, 12));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                cycles($urandom_range(1, 3));
                reset = 1'b0;
            end
            cycles($urandom_range(0, 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
